// File: rtl/pc_select.sv
// pc_select: fetch-PC sequencer (predPC/stallF/redirect in, pc/squashF/pending/squash_cnt out), holds pc stable while imem_wait and defers mid-transaction redirects
module pc_select #(
  parameter logic [63:0] PCINIT = 64'h8000_0000,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      predPC,
  input  logic             imem_wait,
  input  logic             stallF,
  input  logic             redirect_valid,
  input  logic [63:0]      redirect_pc,
  output logic [63:0]      pc,
  output logic             squashF,
  output logic             pending,
  output logic [CNT_W-1:0] squash_cnt
);
  typedef enum logic {RUN, PEND} state_t;
  state_t state, state_n;
  logic [63:0] pc_q, pc_n, pend_pc, pend_n, red_al;
  logic done, defer;
  assign red_al = redirect_pc & ~64'd3;
  assign done = reset & ~imem_wait;
  assign defer = state == RUN & imem_wait & redirect_valid;
  assign pc = reset ? pc_q : '0;
  assign pending = reset & state == PEND;
  always_comb begin
    squashF = done & (state == PEND | redirect_valid);
    pc_n = !done ? pc_q : state == PEND ? pend_pc : redirect_valid ? red_al : stallF ? pc_q : predPC & ~64'd3;
    pend_n = defer ? red_al : pend_pc;
    state_n = defer ? PEND : done ? RUN : state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= PCINIT & ~64'd3;
      state <= RUN;
      pend_pc <= '0;
      squash_cnt <= '0;
    end else begin
      pc_q <= pc_n;
      state <= state_n;
      pend_pc <= pend_n;
      squash_cnt <= squash_cnt + CNT_W'(squashF);
    end
  end
endmodule

// File: tb/tb_pc_select.sv
// tb_pc_select: directed vectors plus per-cycle model comparison for pc_select
module tb_pc_select;
  localparam logic [63:0] B = 64'h8000_0000;
  logic clk, reset, imem_wait, stallF, redirect_valid, squashF, pending, sq4, pd4;
  logic [63:0] predPC, redirect_pc, pc, pc4;
  logic [31:0] squash_cnt;
  logic [3:0] cnt4;
  logic [63:0] m_pc, m_pend_pc;
  logic m_pend, en;
  logic [31:0] m_cnt;
  int nchk, nerr;
  typedef struct {
    logic r, iw, st, rv;
    logic [63:0] rp, pc;
    logic sq, pd;
    logic [31:0] cnt;
  } vec_t;
  vec_t v[$];

  pc_select dut (
    .clk(clk), .reset(reset), .predPC(predPC), .imem_wait(imem_wait), .stallF(stallF),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc), .squashF(squashF),
    .pending(pending), .squash_cnt(squash_cnt)
  );
  pc_select #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .predPC(predPC), .imem_wait(imem_wait), .stallF(stallF),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc4), .squashF(sq4),
    .pending(pd4), .squash_cnt(cnt4)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  assign predPC = m_pc + 64'd4;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_pc <= B;
      m_pend <= 0;
      m_pend_pc <= '0;
      m_cnt <= '0;
    end else if (imem_wait) begin
      if (!m_pend && redirect_valid) begin
        m_pend <= 1;
        m_pend_pc <= redirect_pc & ~64'd3;
      end
    end else if (m_pend) begin
      m_pc <= m_pend_pc;
      m_pend <= 0;
      m_cnt <= m_cnt + 1;
    end else if (redirect_valid) begin
      m_pc <= redirect_pc & ~64'd3;
      m_cnt <= m_cnt + 1;
    end else if (!stallF) m_pc <= predPC & ~64'd3;
  end

  always @(negedge clk) if (en) begin
    chk("m_pc", pc, reset ? m_pc : 64'd0);
    chk("m_squashF", {63'd0, squashF}, {63'd0, reset && !imem_wait && (m_pend || redirect_valid)});
    chk("m_pending", {63'd0, pending}, {63'd0, reset && m_pend});
    chk("m_cnt", {32'd0, squash_cnt}, {32'd0, m_cnt});
    chk("m_cnt4", {60'd0, cnt4}, {60'd0, m_cnt[3:0]});
    chk("m_pc4", pc4, pc);
  end

  task automatic row(input logic r, iw, st, rv, input logic [63:0] rp, ep, input logic sq, pd, input logic [31:0] c);
    v.push_back('{r, iw, st, rv, rp, ep, sq, pd, c});
  endtask

  task automatic drive(input logic r, iw, st, rv, input logic [63:0] rp);
    @(posedge clk);
    #1;
    reset = r;
    imem_wait = iw;
    stallF = st;
    redirect_valid = rv;
    redirect_pc = rp;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    en = 0;
    reset = 0;
    imem_wait = 0;
    stallF = 0;
    redirect_valid = 0;
    redirect_pc = '0;
    row(0, 0, 0, 0, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0, 0, B, 0, 0, 0);
    row(1, 0, 0, 0, 0, B + 'h04, 0, 0, 0);
    row(1, 0, 0, 0, 0, B + 'h08, 0, 0, 0);
    row(1, 0, 0, 0, 0, B + 'h0c, 0, 0, 0);
    row(1, 1, 0, 0, 0, B + 'h10, 0, 0, 0);
    row(1, 1, 0, 0, 0, B + 'h10, 0, 0, 0);
    row(1, 1, 0, 0, 0, B + 'h10, 0, 0, 0);
    row(1, 0, 0, 0, 0, B + 'h10, 0, 0, 0);
    row(1, 0, 0, 0, 0, B + 'h14, 0, 0, 0);
    row(1, 0, 0, 0, 0, B + 'h18, 0, 0, 0);
    row(1, 0, 0, 0, 0, B + 'h1c, 0, 0, 0);
    row(1, 1, 0, 1, B + 'h100, B + 'h20, 0, 0, 0);
    row(1, 1, 0, 0, 0, B + 'h20, 0, 1, 0);
    row(1, 1, 0, 1, B + 'h200, B + 'h20, 0, 1, 0);
    row(1, 0, 0, 0, 0, B + 'h20, 1, 1, 0);
    row(1, 0, 0, 1, B + 'h30, B + 'h100, 1, 0, 1);
    row(1, 0, 1, 1, B + 'h42, B + 'h30, 1, 0, 2);
    row(1, 0, 0, 1, B + 'h50, B + 'h40, 1, 0, 3);
    row(1, 0, 1, 0, 0, B + 'h50, 0, 0, 4);
    row(1, 0, 1, 0, 0, B + 'h50, 0, 0, 4);
    row(1, 0, 0, 0, 0, B + 'h50, 0, 0, 4);
    row(1, 1, 0, 1, B + 'h300, B + 'h54, 0, 0, 4);
    row(1, 1, 0, 0, 0, B + 'h54, 0, 1, 4);
    row(0, 1, 0, 0, 0, 0, 0, 0, 4);
    row(1, 0, 0, 0, 0, B, 0, 0, 0);
    row(1, 0, 0, 0, 0, B + 'h04, 0, 0, 0);
    foreach (v[i]) begin
      drive(v[i].r, v[i].iw, v[i].st, v[i].rv, v[i].rp);
      en = 1;
      @(negedge clk);
      #1;
      chk($sformatf("r%0d_pc", i), pc, v[i].pc);
      chk($sformatf("r%0d_squashF", i), {63'd0, squashF}, {63'd0, v[i].sq});
      chk($sformatf("r%0d_pending", i), {63'd0, pending}, {63'd0, v[i].pd});
      chk($sformatf("r%0d_cnt", i), {32'd0, squash_cnt}, {32'd0, v[i].cnt});
    end
    for (int i = 0; i < 16; i++) drive(1, 0, 0, 1, B);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("wrap_cnt4", {60'd0, cnt4}, 64'd0);
    chk("wrap_cnt32", {32'd0, squash_cnt}, 64'd16);
    chk("wrap_pc", pc, B);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end
endmodule
